ex_stage_mdu: RTL and testbench
===============================

Name: ex_stage_mdu

Overview:
- Consumer end of the decode-to-execute interface.
- Registers the decode outputs (aluop, alusel, source operands, write address, write enable) into an internal ID/EX register.
- Executes logic, shift, arithmetic, move and multiply/divide operations, and owns the HI/LO registers.
- Drives the EX write-back triple, which feeds both the EX/MEM register and decode's EX bypass inputs.
- Runs a multi-cycle divider and raises a stall request to the pipeline controller while it runs.

Parameters:
- DIV_CYCLES, 32, iteration count of the restoring divider; must equal the data width.
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  controller hold for the ID/EX register: 1 = hold, 0 = load.
- aluop_i  in  8  operation code from decode.
- alusel_i  in  3  result class from decode.
- reg1_i  in  32  source operand 1 (rs value, or shift amount).
- reg2_i  in  32  source operand 2 (rt value, or extended immediate).
- waddr_i  in  5  destination register.
- wreg_i  in  1  write enable.
- wdata_o  out  32  result.
- waddr_o  out  5  destination.
- wreg_o  out  1  write enable to EX/MEM and decode bypass.
- stallreq_o  out  1  divider busy.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.

Behaviour:
- Reset (async): ID/EX register cleared to NOP (aluop 0, alusel 000, operands 0, waddr 0, wreg 0); HI = LO = 0; divider state IDLE.
- Outputs during reset: wdata_o = 0, waddr_o = 0, wreg_o = 0, stallreq_o = 0.
- ID/EX register: loads all inputs at the rising edge when stall_i = 0; holds when stall_i = 1.
- Outputs are combinational from the ID/EX register and HI/LO, so a result is visible one cycle after decode presents the instruction.

Operations:
- Op codes (aluop / alusel):
  - NOP 00000000/000.
  - OR 00100101/001, AND 00100100/001, XOR 00100110/001, NOR 00100111/001.
  - SLL 01111100/010, SRL 00000010/010, SRA 00000011/010.
  - ADDU 00100001/100, SUBU 00100011/100, SLT 00101010/100, SLTU 00101011/100.
  - MFHI 00010000/011, MFLO 00010010/011, MTHI 00010001, MTLO 00010011.
  - MULT 00011000, MULTU 00011001, DIV 00011010, DIVU 00011011.
- Shifts: result = reg2 shifted by reg1[4:0]; SRA sign-fills.
- ADDU/SUBU: modulo 2^32, no overflow trap.
- SLT/SLTU: result = 32'h1 or 32'h0.
- wdata_o is selected by alusel; unknown alusel gives 0.
- Unknown aluop: no HI/LO effect.

HI/LO:
- MULT/MULTU: 64-bit combinational product; {HI,LO} = product.
- MTHI: HI = reg1. MTLO: LO = reg1.
- HI/LO commit only at the edge where the instruction leaves EX, i.e. stall_i = 0 and stallreq_o = 0. An instruction held by a downstream stall therefore commits exactly once.
- MFHI/MFLO read the current HI/LO; a commit by the immediately preceding instruction is already visible.

Divider FSM (IDLE, RUN, DONE):
- IDLE:
  - Current op is DIV/DIVU and reg2 != 0: latch operand magnitudes (absolute values if DIV), counter = 0, go to RUN.
  - reg2 == 0: go to DONE with quotient 32'hFFFFFFFF and remainder = reg1.
- RUN: one restoring step per cycle, counter++; after DIV_CYCLES steps go to DONE.
- DONE:
  - Sign fix for DIV: quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Stays in DONE while stall_i = 1.
  - At the edge with stall_i = 0: LO = quotient, HI = remainder, go to IDLE.
- stallreq_o = 1 when the current op is DIV/DIVU and state != DONE.
  - Nonzero divisor: high for 33 cycles.
  - Zero divisor: high for 1 cycle.
- wreg_o is forced to 0 while stallreq_o = 1, so no spurious write reaches EX/MEM.
- If the ID/EX register loads a new instruction while in RUN (controller protocol violation): abort to IDLE with no HI/LO write.
- Reset mid-division: immediate IDLE, HI/LO = 0, stallreq_o = 0.
- Back-to-back DIVs: the second starts in the cycle after the first's commit edge.

Test Plan:
1. ORI-style: aluop OR, reg1 = 32'h0000_1100, reg2 = 32'h0000_0011, waddr 5, wreg 1 → next cycle wdata_o = 32'h1111, waddr_o = 5, wreg_o = 1.
2. SRA: reg1 = 4, reg2 = 32'h8000_0000 → wdata_o = 32'hF800_0000. SLT with reg1 = 32'hFFFF_FFFF, reg2 = 1 → wdata_o = 1. SLTU with the same operands → wdata_o = 0.
3. MULT: reg1 = 32'hFFFF_FFFE (−2), reg2 = 3 → after commit HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFFA. Following MFLO → wdata_o = 32'hFFFF_FFFA.
4. DIV: reg1 = −7, reg2 = 2, stall_i tied to stallreq_o → stallreq_o high for exactly 33 cycles with wreg_o = 0; then LO = −3 (32'hFFFF_FFFD), HI = −1. DIVU 100/7 → LO = 14, HI = 2.
5. DIV by zero: reg1 = 9, reg2 = 0 → stallreq_o high 1 cycle; LO = 32'hFFFF_FFFF, HI = 9.
6. Assert rst in cycle 10 of a RUN → stallreq_o = 0 immediately, HI = LO = 0, outputs NOP. After release, MTHI with reg1 = 32'hA5A5_A5A5 → hi_o = 32'hA5A5_A5A5.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: execute stage with ID/EX register, ALU, HI/LO
// registers and a multi-cycle restoring divider with stall request.
module ex_stage_mdu #(
    parameter int DIV_CYCLES = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        waddr_i,
    input  logic              wreg_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [4:0]        waddr_o,
    output logic              wreg_o,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CW  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int MSB = DATA_W - 1;

    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [4:0]        waddr;
        logic              wreg;
    } id_ex_t;

    id_ex_t ex_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!stall_i) begin
            ex_q <= '{aluop:  aluop_i,
                      alusel: alusel_i,
                      reg1:   reg1_i,
                      reg2:   reg2_i,
                      waddr:  waddr_i,
                      wreg:   wreg_i};
        end
    end

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;

    logic is_div, is_sdiv, commit;
    assign is_div  = (ex_q.aluop == OP_DIV) || (ex_q.aluop == OP_DIVU);
    assign is_sdiv = (ex_q.aluop == OP_DIV);

    assign stallreq_o = is_div && (state_q != S_DONE);
    assign commit     = !stall_i && !stallreq_o;

    // ALU result paths
    logic [DATA_W-1:0] logic_res, shift_res, arith_res, move_res;
    logic [4:0]        shamt;
    assign shamt = ex_q.reg1[4:0];

    always_comb begin
        logic_res = '0;
        unique case (ex_q.aluop)
            OP_OR:   logic_res = ex_q.reg1 | ex_q.reg2;
            OP_AND:  logic_res = ex_q.reg1 & ex_q.reg2;
            OP_XOR:  logic_res = ex_q.reg1 ^ ex_q.reg2;
            OP_NOR:  logic_res = ~(ex_q.reg1 | ex_q.reg2);
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        unique case (ex_q.aluop)
            OP_SLL:  shift_res = ex_q.reg2 << shamt;
            OP_SRL:  shift_res = ex_q.reg2 >> shamt;
            OP_SRA:  shift_res = $unsigned($signed(ex_q.reg2) >>> shamt);
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        unique case (ex_q.aluop)
            OP_ADDU: arith_res = ex_q.reg1 + ex_q.reg2;
            OP_SUBU: arith_res = ex_q.reg1 - ex_q.reg2;
            OP_SLT:  arith_res = {{MSB{1'b0}},
                                  $signed(ex_q.reg1) < $signed(ex_q.reg2)};
            OP_SLTU: arith_res = {{MSB{1'b0}}, ex_q.reg1 < ex_q.reg2};
            default: arith_res = '0;
        endcase
    end

    always_comb begin
        move_res = '0;
        unique case (ex_q.aluop)
            OP_MFHI: move_res = hi_q;
            OP_MFLO: move_res = lo_q;
            default: move_res = '0;
        endcase
    end

    always_comb begin
        wdata_o = '0;
        unique case (ex_q.alusel)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            SEL_ARITH: wdata_o = arith_res;
            SEL_MOVE:  wdata_o = move_res;
            default:   wdata_o = '0;
        endcase
    end

    assign waddr_o = ex_q.waddr;
    assign wreg_o  = ex_q.wreg && !stallreq_o;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    logic [2*DATA_W-1:0] prod;
    always_comb begin
        prod = '0;
        if (ex_q.aluop == OP_MULT) begin
            prod = {{DATA_W{ex_q.reg1[MSB]}}, ex_q.reg1}
                 * {{DATA_W{ex_q.reg2[MSB]}}, ex_q.reg2};
        end else begin
            prod = {{DATA_W{1'b0}}, ex_q.reg1}
                 * {{DATA_W{1'b0}}, ex_q.reg2};
        end
    end

    // Divider datapath: dividend shifts out of quo, quotient bits shift in
    logic [DATA_W-1:0] abs1, abs2, rem_nxt, quo_nxt;
    logic [DATA_W:0]   part, diff;
    logic              ge, neg_q, neg_r;

    assign abs1  = (is_sdiv && ex_q.reg1[MSB]) ? -ex_q.reg1 : ex_q.reg1;
    assign abs2  = (is_sdiv && ex_q.reg2[MSB]) ? -ex_q.reg2 : ex_q.reg2;
    assign part  = {rem_q, quo_q[MSB]};
    assign diff  = part - {1'b0, dvs_q};
    assign ge    = part >= {1'b0, dvs_q};
    assign rem_nxt = ge ? diff[DATA_W-1:0] : part[DATA_W-1:0];
    assign quo_nxt = {quo_q[DATA_W-2:0], ge};
    assign neg_q = is_sdiv && (ex_q.reg1[MSB] ^ ex_q.reg2[MSB]);
    assign neg_r = is_sdiv && ex_q.reg1[MSB];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    if (ex_q.reg2 == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = ex_q.reg1;
                    end else begin
                        state_d = S_RUN;
                        dvs_d   = abs2;
                        quo_d   = abs1;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (!stall_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                        state_d = S_DONE;
                        quo_d   = neg_q ? -quo_nxt : quo_nxt;
                        rem_d   = neg_r ? -rem_nxt : rem_nxt;
                    end
                end
            end
            S_DONE: begin
                if (!stall_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            unique case (ex_q.aluop)
                OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                OP_MTHI: hi_d = ex_q.reg1;
                OP_MTLO: lo_d = ex_q.reg1;
                OP_DIV, OP_DIVU: begin
                    if (state_q == S_DONE) begin
                        lo_d = quo_q;
                        hi_d = rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: directed vectors against an arithmetic reference
// model of the execute stage, checked every falling edge.
module tb_ex_stage_mdu;

    localparam logic [7:0] OR_   = 8'b0010_0101;
    localparam logic [7:0] AND_  = 8'b0010_0100;
    localparam logic [7:0] XOR_  = 8'b0010_0110;
    localparam logic [7:0] NOR_  = 8'b0010_0111;
    localparam logic [7:0] SLL_  = 8'b0111_1100;
    localparam logic [7:0] SRL_  = 8'b0000_0010;
    localparam logic [7:0] SRA_  = 8'b0000_0011;
    localparam logic [7:0] ADDU_ = 8'b0010_0001;
    localparam logic [7:0] SUBU_ = 8'b0010_0011;
    localparam logic [7:0] SLT_  = 8'b0010_1010;
    localparam logic [7:0] SLTU_ = 8'b0010_1011;
    localparam logic [7:0] MFHI_ = 8'b0001_0000;
    localparam logic [7:0] MFLO_ = 8'b0001_0010;
    localparam logic [7:0] MTHI_ = 8'b0001_0001;
    localparam logic [7:0] MTLO_ = 8'b0001_0011;
    localparam logic [7:0] MULT_ = 8'b0001_1000;
    localparam logic [7:0] MULTU_= 8'b0001_1001;
    localparam logic [7:0] DIV_  = 8'b0001_1010;
    localparam logic [7:0] DIVU_ = 8'b0001_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_stall = 1'b0;
    logic        stall_i;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  waddr_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_o;
    logic [4:0]  waddr_o;
    logic        wreg_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_err = 0;
    int n_checks = 0;

    // pipeline controller: hold ID/EX while the divider asks for it
    assign stall_i = ext_stall | stallreq_o;

    always #5 clk = ~clk;

    ex_stage_mdu #(.DIV_CYCLES(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i),
        .waddr_i(waddr_i), .wreg_i(wreg_i),
        .wdata_o(wdata_o), .waddr_o(waddr_o), .wreg_o(wreg_o),
        .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    // reference model state
    logic [7:0]  m_op = '0;
    logic [2:0]  m_sel = '0;
    logic [31:0] m_r1 = '0, m_r2 = '0, m_hi = '0, m_lo = '0;
    logic [4:0]  m_wa = '0;
    logic        m_we = 1'b0;
    int          m_left = 0;

    function automatic bit m_isdiv(input logic [7:0] op);
        return op == DIV_ || op == DIVU_;
    endfunction

    function automatic bit exp_stall();
        return m_isdiv(m_op) && m_left > 0;
    endfunction

    function automatic logic [31:0] exp_wdata();
        logic [31:0] r;
        r = '0;
        if (m_sel == 3'b001) begin
            if (m_op == OR_)  r = m_r1 | m_r2;
            if (m_op == AND_) r = m_r1 & m_r2;
            if (m_op == XOR_) r = m_r1 ^ m_r2;
            if (m_op == NOR_) r = ~(m_r1 | m_r2);
        end else if (m_sel == 3'b010) begin
            if (m_op == SLL_) r = m_r2 << m_r1[4:0];
            if (m_op == SRL_) r = m_r2 >> m_r1[4:0];
            if (m_op == SRA_) r = 32'($signed(m_r2) >>> m_r1[4:0]);
        end else if (m_sel == 3'b100) begin
            if (m_op == ADDU_) r = m_r1 + m_r2;
            if (m_op == SUBU_) r = m_r1 - m_r2;
            if (m_op == SLT_)  r = (int'(m_r1) < int'(m_r2)) ? 1 : 0;
            if (m_op == SLTU_) r = (m_r1 < m_r2) ? 1 : 0;
        end else if (m_sel == 3'b011) begin
            if (m_op == MFHI_) r = m_hi;
            if (m_op == MFLO_) r = m_lo;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_op = '0; m_sel = '0; m_r1 = '0; m_r2 = '0;
            m_wa = '0; m_we = 1'b0; m_hi = '0; m_lo = '0;
            m_left = 0;
        end else begin
            longint p;
            if (!stall_i && !exp_stall()) begin
                if (m_op == MULT_) begin
                    p = longint'(int'(m_r1)) * longint'(int'(m_r2));
                    {m_hi, m_lo} = p;
                end else if (m_op == MULTU_) begin
                    p = longint'(m_r1) * longint'(m_r2);
                    {m_hi, m_lo} = p;
                end else if (m_op == MTHI_) begin
                    m_hi = m_r1;
                end else if (m_op == MTLO_) begin
                    m_lo = m_r1;
                end else if (m_isdiv(m_op) && m_r2 == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = m_r1;
                end else if (m_op == DIV_) begin
                    m_lo = 32'(int'(m_r1) / int'(m_r2));
                    m_hi = 32'(int'(m_r1) % int'(m_r2));
                end else if (m_op == DIVU_) begin
                    m_lo = m_r1 / m_r2;
                    m_hi = m_r1 % m_r2;
                end
            end
            if (m_left > 0) m_left--;
            if (!stall_i) begin
                m_op = aluop_i; m_sel = alusel_i; m_r1 = reg1_i;
                m_r2 = reg2_i; m_wa = waddr_i; m_we = wreg_i;
                m_left = m_isdiv(aluop_i) ? ((reg2_i != 0) ? 33 : 1) : 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("wdata_o", wdata_o, exp_wdata());
        chk("waddr_o", 32'(waddr_o), 32'(m_wa));
        chk("wreg_o", 32'(wreg_o), 32'(m_we && !exp_stall()));
        chk("stallreq_o", 32'(stallreq_o), 32'(exp_stall()));
        chk("hi_o", hi_o, m_hi);
        chk("lo_o", lo_o, m_lo);
    end

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
        waddr_i = wa; wreg_i = we;
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we);
        drive(op, sel, a, b, wa, we);
        @(negedge clk);
    endtask

    task automatic count_stall(output int n);
        n = 0;
        while (stallreq_o && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst wdata", wdata_o, 32'h0);
        chk("rst stallreq", 32'(stallreq_o), 32'h0);
        chk("rst hi", hi_o, 32'h0);
        rst = 1'b0;

        issue(OR_, 3'b001, 32'h0000_1100, 32'h0000_0011, 5'd5, 1'b1);
        chk("ori wdata", wdata_o, 32'h0000_1111);
        chk("ori waddr", 32'(waddr_o), 32'd5);
        chk("ori wreg", 32'(wreg_o), 32'd1);
        issue(AND_, 3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6, 1'b1);
        issue(XOR_, 3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 5'd7, 1'b1);
        issue(NOR_, 3'b001, 32'h0000_00F0, 32'h0F00_0000, 5'd8, 1'b1);
        issue(SLL_, 3'b010, 32'd31, 32'h0000_0003, 5'd9, 1'b1);
        issue(SRL_, 3'b010, 32'd4, 32'h8000_0000, 5'd10, 1'b1);
        issue(SRA_, 3'b010, 32'd4, 32'h8000_0000, 5'd11, 1'b1);
        chk("sra", wdata_o, 32'hF800_0000);
        issue(SLT_, 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd12, 1'b1);
        chk("slt", wdata_o, 32'h1);
        issue(SLTU_, 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd13, 1'b1);
        chk("sltu", wdata_o, 32'h0);
        issue(ADDU_, 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd14, 1'b1);
        chk("addu wrap", wdata_o, 32'h0);
        issue(SUBU_, 3'b100, 32'd0, 32'd1, 5'd15, 1'b1);
        chk("subu wrap", wdata_o, 32'hFFFF_FFFF);
        issue(OR_, 3'b111, 32'h1, 32'h2, 5'd16, 1'b1);
        issue(8'hEE, 3'b001, 32'h1, 32'h2, 5'd17, 1'b1);

        issue(MULT_, 3'b000, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
        issue(MFLO_, 3'b011, 32'd0, 32'd0, 5'd2, 1'b1);
        chk("mult hi", hi_o, 32'hFFFF_FFFF);
        chk("mult lo", lo_o, 32'hFFFF_FFFA);
        chk("mflo", wdata_o, 32'hFFFF_FFFA);
        issue(MULTU_, 3'b000, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
        issue(MFHI_, 3'b011, 32'd0, 32'd0, 5'd3, 1'b1);
        chk("multu hi", hi_o, 32'h0000_0002);

        issue(DIV_, 3'b000, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
        chk("div wreg", 32'(wreg_o), 32'd0);
        drive(DIVU_, 3'b000, 32'd100, 32'd7, 5'd0, 1'b0);
        count_stall(n);
        chk("div stall len", 32'(n), 32'd33);
        @(negedge clk);
        chk("div lo", lo_o, 32'hFFFF_FFFD);
        chk("div hi", hi_o, 32'hFFFF_FFFF);
        chk("b2b start", 32'(stallreq_o), 32'd1);
        drive(MFHI_, 3'b011, 32'd0, 32'd0, 5'd4, 1'b1);
        count_stall(n);
        chk("divu stall len", 32'(n), 32'd33);
        @(negedge clk);
        chk("divu lo", lo_o, 32'd14);
        chk("divu hi", hi_o, 32'd2);
        chk("mfhi", wdata_o, 32'd2);

        issue(DIV_, 3'b000, 32'd9, 32'd0, 5'd0, 1'b0);
        drive(MFLO_, 3'b011, 32'd0, 32'd0, 5'd5, 1'b1);
        count_stall(n);
        chk("div0 stall len", 32'(n), 32'd1);
        @(negedge clk);
        chk("div0 lo", lo_o, 32'hFFFF_FFFF);
        chk("div0 hi", hi_o, 32'd9);

        issue(MTLO_, 3'b000, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
        ext_stall = 1'b1;
        drive(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("held mtlo", lo_o, 32'hFFFF_FFFF);
        ext_stall = 1'b0;
        @(negedge clk);
        chk("mtlo", lo_o, 32'h1234_5678);

        issue(DIVU_, 3'b000, 32'hFFFF_FFF0, 32'd3, 5'd0, 1'b0);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst stallreq", 32'(stallreq_o), 32'd0);
        chk("rst hi mid", hi_o, 32'd0);
        chk("rst lo mid", lo_o, 32'd0);
        chk("rst wreg", 32'(wreg_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(MTHI_, 3'b000, 32'hA5A5_A5A5, 32'd0, 5'd0, 1'b0);
        issue(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        chk("mthi", hi_o, 32'hA5A5_A5A5);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
